sipo_frame_rx: RTL and testbench
================================

Name: sipo_frame_rx

Overview:
- Serial frame receiver built around a SIPO shift core.
- Consumes a one-bit serial line qualified by a bit strobe: detects a start bit, shifts WIDTH data bits LSB-first, checks optional even parity and the stop bit, then presents the word on a valid/ready holding register.
- Sits between the serial pin logic and any parallel consumer of received words.

Parameters:
- WIDTH, 4, data bits per frame (legal range 2..16).
- PARITY_EN, 1, 1 = an even-parity bit follows the data bits; 0 = no parity bit.

Ports:
- clk  input  1  system clock; all logic on posedge.
- clr_n  input  1  synchronous active-low reset.
- din  input  1  serial line; idles high.
- din_en  input  1  bit strobe; din is sampled only on cycles where din_en=1.
- dout  output  WIDTH  received word; bit 0 is the first data bit received.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1.
- parity_err  output  1  one-cycle pulse: parity mismatch, frame dropped.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0, frame dropped.
- overrun  output  1  one-cycle pulse: good frame dropped because the holding register was full.

Behaviour:
- Reset (clr_n=0 at posedge) clears the following, overriding everything including mid-frame: state=IDLE, shift reg=0, bit counter=0, dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0.
- FSM states are IDLE, DATA, PARITY, STOP. State changes only on cycles with din_en=1, except the handshake, which is evaluated every cycle.
- IDLE: on din_en=1 and din=0, go to DATA with counter=0. On din=1, stay in IDLE.
- DATA: on each strobe, shift right with din entering the MSB, so the first bit ends in bit 0. Increment the counter and accumulate running XOR parity. After the WIDTH-th bit, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: on the strobe, set a mismatch flag if din != XOR of the data bits, then go to STOP.
- STOP: on the strobe, go to IDLE and resolve the frame in priority order:
  - din=0: pulse frame_err; discard the frame.
  - Else, parity mismatch: pulse parity_err; discard the frame.
  - Else, holding register free, or being accepted this same cycle: load dout and set dout_valid=1.
  - Else: pulse overrun; keep the old dout and discard the new word.
- Latency: dout_valid rises on the clock edge that samples the stop bit and is visible the next cycle.
- Handshake:
  - dout_valid=1 and dout_ready=1 at posedge clears dout_valid.
  - A simultaneous accept and new load leaves dout_valid=1 with the new word (back-to-back, no bubble).
  - dout stays stable while dout_valid=1 and not accepted.
- Error pulses last exactly one cycle. A back-to-back start bit is allowed on the strobe immediately after the stop bit.
- The FSM ignores din while din_en=0. Strobes may be any number of cycles apart, including every cycle.
- Parity arithmetic: even parity means the XOR of the WIDTH data bits plus the parity bit must equal 0.

Test Plan:
- Strobe every cycle, WIDTH=4, PARITY_EN=1; send 0,1,1,0,1,1,1 (start, data LSB-first for 4'b1011, parity 1, stop) with dout_ready=0 -> dout=4'b1011 and dout_valid=1 the cycle after the stop strobe; no error pulses.
- Same frame with parity bit 0 -> parity_err one-cycle pulse; dout_valid stays 0; dout stays 4'b0000.
- Frame for 4'b0110 (parity 0) with stop bit 0 -> frame_err pulse only; the next frame for 4'b1011 is received correctly.
- Hold dout_ready=0 after 4'b1011 is received, then send a good 4'b0101 -> overrun pulse; dout stays 4'b1011. Then raise dout_ready -> dout_valid falls next cycle.
- dout_ready=1 on exactly the stop-strobe cycle of a second frame 4'b0011 while 4'b1011 is pending -> dout=4'b0011 and dout_valid stays 1; no overrun.
- din_en pulsed every 3rd cycle; assert clr_n=0 after the 2nd data bit, release, then send 4'b1001 -> partial frame lost; 4'b1001 received cleanly; all outputs 0 during reset.

Source files
------------

// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB-first, optional even parity, stop bit.
// Latency: dout_valid is visible the cycle after the stop-bit strobe. Backpressure: one-word holding register; a full register drops the new frame and pulses overrun.
module sipo_frame_rx #(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             din,
    input  logic             din_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              par_q, par_d;
    logic              perr_q, perr_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            par_q        <= par_d;
            perr_q       <= perr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        par_d        = par_q;
        perr_d       = perr_q;
        dout_d       = dout_q;
        // Handshake runs every cycle, independent of the bit strobe.
        dout_valid_d = dout_valid_q & ~dout_ready;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        if (din_en) begin
            case (state_q)
                IDLE: begin
                    if (!din) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                        perr_d  = 1'b0;
                    end
                end
                DATA: begin
                    shift_d = {din, shift_q[WIDTH-1:1]};
                    par_d   = par_q ^ din;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    perr_d  = din ^ par_q;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!din) begin
                        frame_err_d = 1'b1;
                    end else if (perr_q) begin
                        parity_err_d = 1'b1;
                    end else if (!dout_valid_q || dout_ready) begin
                        dout_d       = shift_q;
                        dout_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx (WIDTH=4, PARITY_EN=1).
module tb_sipo_frame_rx;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       din;
    logic       din_en;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int gap    = 0;

    always #5 clk = ~clk;

    sipo_frame_rx #(.WIDTH(4), .PARITY_EN(1)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .din       (din),
        .din_en    (din_en),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobed bit; gap idle cycles follow when strobes are spread out.
    task automatic send_bit(input logic b);
        din    = b;
        din_en = 1'b1;
        tick();
        if (gap > 0) begin
            din_en = 1'b0;
            repeat (gap) tick();
        end
    endtask

    // Sends start, data LSB-first, parity, stop; dout_ready held at rdy_stop only on the stop strobe.
    task automatic send_frame(input logic [3:0] data, input logic par, input logic stop,
                              input logic rdy_stop);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(data[i]);
        send_bit(par);
        dout_ready = rdy_stop;
        send_bit(stop);
        dout_ready = 1'b0;
        din        = 1'b1;
        din_en     = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] d, input logic v,
                                 input logic pe, input logic fe, input logic ov);
        check({tag, "_dout"}, 16'(dout), 16'(d));
        check({tag, "_valid"}, 16'(dout_valid), 16'(v));
        check({tag, "_perr"}, 16'(parity_err), 16'(pe));
        check({tag, "_ferr"}, 16'(frame_err), 16'(fe));
        check({tag, "_ovr"}, 16'(overrun), 16'(ov));
    endtask

    initial begin
        clr_n      = 1'b0;
        din        = 1'b1;
        din_en     = 1'b0;
        dout_ready = 1'b0;
        repeat (2) tick();
        check_outputs("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        clr_n = 1'b1;
        tick();

        // Bad parity on 1011: parity should be 1, 0 is sent.
        send_frame(4'b1011, 1'b0, 1'b1, 1'b0);
        check_outputs("badpar", 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("badpar_pulse_end", 16'(parity_err), 16'd0);

        send_frame(4'b1011, 1'b1, 1'b1, 1'b0);
        check_outputs("good1", 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("accept1_valid", 16'(dout_valid), 16'd0);

        // Stop bit 0 on 0110.
        send_frame(4'b0110, 1'b0, 1'b0, 1'b0);
        check_outputs("frmerr", 4'b1011, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("frmerr_pulse_end", 16'(frame_err), 16'd0);

        send_frame(4'b1011, 1'b1, 1'b1, 1'b0);
        check_outputs("good2", 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);

        // Holding register full: 0101 is dropped.
        send_frame(4'b0101, 1'b0, 1'b1, 1'b0);
        check_outputs("ovr", 4'b1011, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("ovr_pulse_end", 16'(overrun), 16'd0);
        check("ovr_dout_hold", 16'(dout), 16'b1011);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("accept2_valid", 16'(dout_valid), 16'd0);

        // Back-to-back frames; accept coincides with the second stop strobe.
        send_frame(4'b1011, 1'b1, 1'b1, 1'b0);
        check_outputs("b2b_first", 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0011, 1'b0, 1'b1, 1'b1);
        check_outputs("b2b_second", 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("b2b_hold_valid", 16'(dout_valid), 16'd1);
        check("b2b_hold_dout", 16'(dout), 16'b0011);

        // Strobe every 3rd cycle; reset lands mid-frame with a word still pending.
        gap = 2;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        clr_n = 1'b0;
        tick();
        check_outputs("midreset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outputs("midreset2", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        clr_n = 1'b1;
        tick();
        send_frame(4'b1001, 1'b0, 1'b1, 1'b0);
        check_outputs("slow", 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("slow_hold_dout", 16'(dout), 16'b1001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
